// File: rtl/pwm_cmd_ctrl.sv
// SPI command sequencer for the PWM block: parses 3-byte frames into double-buffered
// compare writes and arm/disarm commands, with a link-loss watchdog forcing failsafe.
module pwm_cmd_ctrl #(
    parameter int               N_CH     = 4,
    parameter int               CMP_W    = 16,
    parameter logic [15:0]      MAX_CMP  = 16'hFFFF,
    parameter logic [CMP_W-1:0] FAILSAFE = '0,
    parameter int               WDOG_CYC = 1_000_000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_byte,
    input  logic                  cs_n_s,
    input  logic                  period_tick,
    output logic [N_CH*CMP_W-1:0] cmp,
    output logic                  armed,
    output logic                  frame_err,
    output logic                  wdog_trip,
    output logic [3:0]            status
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GOT_CMD,
        S_GOT_DH,
        S_EXEC
    } state_t;

    localparam int               WD_W    = (WDOG_CYC > 2) ? $clog2(WDOG_CYC) : 1;
    localparam logic [WD_W-1:0]  WD_LAST = WD_W'(WDOG_CYC - 1);

    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_ARM   = 2'b10;
    localparam logic [1:0] OP_BAD   = 2'b11;

    state_t              r_state;
    logic [7:0]          r_cmd;
    logic [7:0]          r_dh;
    logic [7:0]          r_dl;
    logic [CMP_W-1:0]    r_shadow [N_CH];
    logic [CMP_W-1:0]    r_cmp    [N_CH];
    logic                r_armed;
    logic                r_frame_err;
    logic                r_wdog_trip;
    logic                r_wdog_sticky;
    logic                r_err_sticky;
    logic                r_clamp_sticky;
    logic [WD_W-1:0]     r_wdog_cnt;

    logic [1:0]          w_op;
    logic [3:0]          w_ch;
    logic [15:0]         w_val;
    logic                w_cmd_ok;
    logic                w_exec_ok;
    logic                w_exec_bad;
    logic                w_abort;
    logic                w_clamp;
    logic [CMP_W-1:0]    w_wval;
    logic                w_write;
    logic                w_arm_cmd;
    logic                w_trip;

    assign w_op       = r_cmd[7:6];
    assign w_ch       = r_cmd[3:0];
    assign w_val      = {r_dh, r_dl};
    assign w_cmd_ok   = (w_op != OP_BAD) && (r_cmd[5:4] == 2'b00) &&
                        !((w_op == OP_WRITE) && ({1'b0, w_ch} >= 5'(N_CH)));
    assign w_exec_ok  = (r_state == S_EXEC) && w_cmd_ok;
    assign w_exec_bad = (r_state == S_EXEC) && !w_cmd_ok;
    assign w_abort    = cs_n_s && ((r_state == S_GOT_CMD) || (r_state == S_GOT_DH));
    assign w_clamp    = (w_val > MAX_CMP);
    assign w_wval     = w_clamp ? MAX_CMP[CMP_W-1:0] : w_val[CMP_W-1:0];
    assign w_write    = w_exec_ok && (w_op == OP_WRITE);
    assign w_arm_cmd  = w_exec_ok && (w_op == OP_ARM);
    // A valid frame executing in the same cycle always pre-empts a watchdog trip.
    assign w_trip     = r_armed && !w_exec_ok && (r_wdog_cnt == WD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cmd   <= '0;
            r_dh    <= '0;
            r_dl    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (rx_valid) begin
                        r_cmd   <= rx_byte;
                        r_state <= S_GOT_CMD;
                    end
                end
                S_GOT_CMD: begin
                    if (cs_n_s) begin
                        r_state <= S_IDLE;
                    end else if (rx_valid) begin
                        r_dh    <= rx_byte;
                        r_state <= S_GOT_DH;
                    end
                end
                S_GOT_DH: begin
                    if (cs_n_s) begin
                        r_state <= S_IDLE;
                    end else if (rx_valid) begin
                        r_dl    <= rx_byte;
                        r_state <= S_EXEC;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wdog_cnt <= '0;
        end else if (w_exec_ok || !r_armed || w_trip) begin
            r_wdog_cnt <= '0;
        end else begin
            r_wdog_cnt <= r_wdog_cnt + WD_W'(1);
        end
    end

    // Shadows take writes; the live compare set only moves on a period boundary
    // unless the watchdog forces everything to failsafe at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) begin
                r_shadow[i] <= FAILSAFE;
                r_cmp[i]    <= FAILSAFE;
            end
        end else if (w_trip) begin
            for (int i = 0; i < N_CH; i++) begin
                r_shadow[i] <= FAILSAFE;
                r_cmp[i]    <= FAILSAFE;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (w_write && (w_ch == 4'(i))) begin
                    r_shadow[i] <= w_wval;
                end
                if (period_tick) begin
                    r_cmp[i] <= r_armed ? r_shadow[i] : FAILSAFE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_armed        <= 1'b0;
            r_frame_err    <= 1'b0;
            r_wdog_trip    <= 1'b0;
            r_wdog_sticky  <= 1'b0;
            r_err_sticky   <= 1'b0;
            r_clamp_sticky <= 1'b0;
        end else begin
            r_frame_err <= w_abort || w_exec_bad;
            r_wdog_trip <= w_trip;
            if (w_arm_cmd) begin
                r_armed <= r_dl[0];
            end else if (w_trip) begin
                r_armed <= 1'b0;
            end
            if (w_arm_cmd && r_dl[0]) begin
                r_wdog_sticky  <= 1'b0;
                r_err_sticky   <= 1'b0;
                r_clamp_sticky <= 1'b0;
            end else begin
                if (w_trip)                 r_wdog_sticky  <= 1'b1;
                if (w_abort || w_exec_bad)  r_err_sticky   <= 1'b1;
                if (w_write && w_clamp)     r_clamp_sticky <= 1'b1;
            end
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_cmp
        assign cmp[g*CMP_W +: CMP_W] = r_cmp[g];
    end

    assign armed     = r_armed;
    assign frame_err = r_frame_err;
    assign wdog_trip = r_wdog_trip;
    assign status    = {r_armed, r_wdog_sticky, r_err_sticky, r_clamp_sticky};

endmodule

// File: tb/tb_pwm_cmd_ctrl.sv
// Directed self-checking bench for pwm_cmd_ctrl: 4 channels, failsafe 1500,
// clamp at 2000 and a 64-cycle watchdog so every path is reached quickly.
module tb_pwm_cmd_ctrl;

    localparam int N_CH  = 4;
    localparam int CMP_W = 16;
    localparam logic [63:0] ALL_FS = 64'h05DC_05DC_05DC_05DC;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  rx_valid;
    logic [7:0]            rx_byte;
    logic                  cs_n_s;
    logic                  period_tick;
    logic [N_CH*CMP_W-1:0] cmp;
    logic                  armed;
    logic                  frame_err;
    logic                  wdog_trip;
    logic [3:0]            status;

    int checks = 0;
    int errors = 0;
    int pulseCount = 0;
    int pulseMark;
    int waitCycles;

    pwm_cmd_ctrl #(
        .N_CH     (N_CH),
        .CMP_W    (CMP_W),
        .MAX_CMP  (16'd2000),
        .FAILSAFE (16'd1500),
        .WDOG_CYC (64)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_valid    (rx_valid),
        .rx_byte     (rx_byte),
        .cs_n_s      (cs_n_s),
        .period_tick (period_tick),
        .cmp         (cmp),
        .armed       (armed),
        .frame_err   (frame_err),
        .wdog_trip   (wdog_trip),
        .status      (status)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err || wdog_trip) pulseCount++;
    end

    // One byte pulse followed by a gap cycle, so a third byte's gap is its EXEC cycle.
    task automatic applyStimulus(input logic [7:0] b);
        @(posedge clk); #1;
        rx_valid = 1'b1;
        rx_byte  = b;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic sendFrame(input logic [7:0] c, input logic [7:0] dh, input logic [7:0] dl);
        applyStimulus(c);
        applyStimulus(dh);
        applyStimulus(dl);
    endtask

    task automatic pulseTick();
        @(posedge clk); #1;
        period_tick = 1'b1;
        @(posedge clk); #1;
        period_tick = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        rx_valid    = 1'b0;
        rx_byte     = 8'h00;
        cs_n_s      = 1'b0;
        period_tick = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        checkOutput("reset_cmp", cmp, ALL_FS);
        checkOutput("reset_armed", 64'(armed), 64'd0);
        checkOutput("reset_status", 64'(status), 64'h0);
        checkOutput("reset_pulses", 64'({frame_err, wdog_trip}), 64'd0);

        pulseMark = pulseCount;
        repeat (128) @(posedge clk);
        #1;
        checkOutput("idle_no_pulses", 64'(pulseCount - pulseMark), 64'd0);
        pulseTick();
        checkOutput("idle_tick_cmp", cmp, ALL_FS);

        sendFrame(8'h80, 8'h00, 8'h01);
        checkOutput("arm_status", 64'(status), 64'h8);
        checkOutput("arm_cmp_wait", cmp, ALL_FS);

        sendFrame(8'h42, 8'h03, 8'hE8);
        checkOutput("wr2_before_tick", cmp, ALL_FS);
        pulseTick();
        checkOutput("wr2_after_tick", cmp, 64'h05DC_03E8_05DC_05DC);

        sendFrame(8'h41, 8'hFF, 8'hFF);
        checkOutput("clamp_status", 64'(status), 64'h9);
        pulseTick();
        checkOutput("clamp_cmp", cmp, 64'h05DC_03E8_07D0_05DC);

        applyStimulus(8'h41);
        applyStimulus(8'h12);
        cs_n_s = 1'b1;
        @(posedge clk); #1;
        cs_n_s = 1'b0;
        checkOutput("abort_pulse", 64'(frame_err), 64'd1);
        checkOutput("abort_status", 64'(status), 64'hB);
        @(posedge clk); #1;
        checkOutput("abort_pulse_end", 64'(frame_err), 64'd0);
        pulseTick();
        checkOutput("abort_no_write", cmp, 64'h05DC_03E8_07D0_05DC);
        sendFrame(8'h40, 8'h00, 8'h64);
        pulseTick();
        checkOutput("after_abort_ok", cmp, 64'h05DC_03E8_07D0_0064);

        sendFrame(8'h45, 8'h00, 8'h10);
        checkOutput("bad_ch_err", 64'(frame_err), 64'd1);
        sendFrame(8'hC0, 8'h00, 8'h00);
        checkOutput("bad_op_err", 64'(frame_err), 64'd1);
        sendFrame(8'h90, 8'h00, 8'h00);
        checkOutput("bad_rsv_err", 64'(frame_err), 64'd1);
        checkOutput("bad_rsv_armed", 64'(armed), 64'd1);
        pulseTick();
        checkOutput("bad_no_write", cmp, 64'h05DC_03E8_07D0_0064);

        sendFrame(8'h80, 8'h00, 8'h00);
        checkOutput("disarm_status", 64'(status), 64'h3);
        checkOutput("disarm_cmp_hold", cmp, 64'h05DC_03E8_07D0_0064);
        pulseTick();
        checkOutput("disarm_cmp_fs", cmp, ALL_FS);
        sendFrame(8'h80, 8'h00, 8'h01);
        checkOutput("rearm_status", 64'(status), 64'h8);
        pulseTick();
        checkOutput("rearm_shadow_kept", cmp, 64'h05DC_03E8_07D0_0064);

        applyStimulus(8'h43);
        applyStimulus(8'h00);
        @(posedge clk); #1;
        rx_valid = 1'b1;
        rx_byte  = 8'hC8;
        @(posedge clk); #1;
        rx_valid    = 1'b0;
        period_tick = 1'b1;
        @(posedge clk); #1;
        period_tick = 1'b0;
        checkOutput("exec_tick_old", cmp, 64'h05DC_03E8_07D0_0064);
        pulseTick();
        checkOutput("exec_tick_new", cmp, 64'h00C8_03E8_07D0_0064);

        waitCycles = 0;
        while (!wdog_trip && waitCycles < 200) begin
            @(posedge clk); #1;
            waitCycles++;
        end
        checkOutput("wdog_latency", 64'(waitCycles), 64'd62);
        checkOutput("wdog_pulse", 64'(wdog_trip), 64'd1);
        checkOutput("wdog_armed", 64'(armed), 64'd0);
        checkOutput("wdog_cmp", cmp, ALL_FS);
        checkOutput("wdog_status", 64'(status), 64'h4);
        @(posedge clk); #1;
        checkOutput("wdog_pulse_end", 64'(wdog_trip), 64'd0);
        sendFrame(8'h80, 8'h00, 8'h01);
        checkOutput("wdog_rearm_status", 64'(status), 64'h8);
        pulseTick();
        checkOutput("wdog_shadow_cleared", cmp, ALL_FS);

        sendFrame(8'h40, 8'hFF, 8'hFF);
        pulseTick();
        checkOutput("pre_reset_cmp", cmp, 64'h05DC_05DC_05DC_07D0);
        applyStimulus(8'h40);
        applyStimulus(8'h00);
        #2 rst_n = 1'b0;
        #10 rst_n = 1'b1;
        #1;
        checkOutput("midreset_cmp", cmp, ALL_FS);
        checkOutput("midreset_status", 64'(status), 64'h0);
        sendFrame(8'h80, 8'h00, 8'h01);
        checkOutput("postreset_arm", 64'(status), 64'h8);
        pulseTick();
        checkOutput("postreset_cmp", cmp, ALL_FS);
        sendFrame(8'h80, 8'h00, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
